mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single-ported memory between instruction fetch (IF) and the load/store path (LS). Arbitrates requests and sequences each transaction through a small FSM. Forwards memWR/memCtrl-style controls to the memory, flags malformed accesses and timeouts, and bounds fetch starvation. Sits between the fetch unit / LSU and the memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 15, max cycles of mem_ready low in a transaction before abort (1..255)
FETCH_STARVE, 4, max consecutive LS grants while if_req is pending (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch data, valid with if_ack
if_ack  out  1  one-cycle completion pulse
if_err  out  1  fetch timed out, valid with if_ack
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  store when 1 (memWR)
ls_ctrl  in  3  memCtrl: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_rdata  out  DATA_W  load data, valid with ls_ack
ls_ack  out  1  one-cycle completion pulse
ls_err  out  1  malformed access or timeout, valid with ls_ack
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_ctrl  out  3  access size/sign, same encoding as ls_ctrl
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req=1
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered. Reset: state IDLE, all outputs 0, wait_cnt=0, starve_cnt=0.
- States: IDLE, FETCH, DATA, RESP.
- IDLE:
  - Only if_req: grant IF. Latch if_addr; mem_ctrl=010; mem_we=0; mem_req=1; go to FETCH.
  - Only ls_req: grant LS. Latch ls_we/ls_ctrl/ls_addr/ls_wdata; drive mem_*; go to DATA.
  - Both pending: LS wins unless starve_cnt==FETCH_STARVE, in which case IF wins.
- Malformed LS request:
  - Definition: ls_we=0 with ctrl in {101,110,111}, or ls_we=1 with ctrl not in {101,110,111}.
  - Response: no mem_req. Go directly to RESP with ls_err=1, ls_rdata=0.
- starve_cnt:
  - Increments (saturating) on each LS grant made while if_req=1.
  - Clears on IF grant.
  - Clears on any grant made while if_req=0.
- FETCH/DATA:
  - mem_req and mem_* fields stay stable until mem_ready=1.
  - On mem_ready: capture mem_rdata into if_rdata or ls_rdata (stores give 0), drop mem_req, go to RESP.
  - wait_cnt counts cycles with mem_ready=0. If wait_cnt reaches MAX_WAIT: drop mem_req, set if_err or ls_err, rdata=0, go to RESP.
  - wait_cnt clears on entry to FETCH/DATA.
- RESP:
  - The granted side's ack is high for exactly 1 cycle; err and rdata are valid with it, then return to IDLE.
  - Requesters may deassert req, or present a new request, from the cycle after ack.
  - Requests are not evaluated in RESP.
- Latency (IDLE grant at cycle 0, mem_ready first seen at cycle k≥1): ack at k+1; next grant no earlier than k+2. Minimum 2 cycles from grant to ack.
- if_ack and ls_ack are never high together. Neither acks without a prior grant.
- Err outputs are 0 whenever their ack is 0. Rdata holds its last value otherwise.
- rst mid-transaction: next cycle mem_req=0, no ack issued, state IDLE, counters cleared.
- Request inputs are ignored while rst=1.

Test Plan:
- Fetch only: if_req, if_addr=0x100; mem_ready 2 cycles after mem_req rises, mem_rdata=0x00000013 -> mem_ctrl=010, mem_we=0, mem_addr=0x100; if_ack one cycle after mem_ready; if_rdata=0x00000013; if_err=0.
- Simultaneous: if_req and ls_req (LW, 0x200) in the same cycle, mem_ready immediate -> LS served first, then IF. Acks are separate, non-overlapping one-cycle pulses; mem_addr sequence is 0x200, then if_addr.
- Starvation: ls_req held continuously, if_req held, FETCH_STARVE=4 -> exactly 4 LS grants, then an IF grant, then LS resumes.
- Malformed: ls_we=0, ls_ctrl=110 -> mem_req stays 0; ls_ack=1 and ls_err=1 one cycle after grant; ls_rdata=0. Also ls_we=1, ls_ctrl=010 -> same response.
- Timeout: LS store SW, mem_ready held 0, MAX_WAIT=15 -> mem_req high for 15 cycles then drops; ls_ack=1 with ls_err=1; memory sees no further request.
- Reset mid-DATA: rst pulsed while mem_req=1 -> next cycle mem_req=0, busy=0, no ls_ack. A fresh if_req afterwards is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch path (IF) and the load/store path (LS). Every transaction goes
// IDLE -> FETCH/DATA -> RESP -> IDLE. A malformed load/store skips the memory
// and goes straight to RESP. Stalled memory accesses are aborted after
// MAX_WAIT not-ready cycles. Fetch starvation is bounded by FETCH_STARVE.
// All outputs come straight from flops.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_WAIT     = 15,
  parameter int FETCH_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_ctrl,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] CTRL_LW = 3'b010;
  localparam logic [2:0] CTRL_SB = 3'b101;
  localparam logic [2:0] CTRL_SH = 3'b110;
  localparam logic [2:0] CTRL_SW = 3'b111;

  localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_WAIT);
  localparam logic [3:0] STARVE_LIMIT = 4'(FETCH_STARVE);

  // State and counters
  state_t            state_q,      state_d;
  logic [7:0]        wait_cnt_q,   wait_cnt_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;

  // Registered outputs
  logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
  logic              if_ack_q,     if_ack_d;
  logic              if_err_q,     if_err_d;
  logic [DATA_W-1:0] ls_rdata_q,   ls_rdata_d;
  logic              ls_ack_q,     ls_ack_d;
  logic              ls_err_q,     ls_err_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [2:0]        mem_ctrl_q,   mem_ctrl_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              busy_q,       busy_d;

  // Arbitration decode
  logic       ls_is_store;
  logic       ls_malformed;
  logic       starve_hit;
  logic       grant_if;
  logic       grant_ls;
  logic [3:0] starve_inc;
  logic       wait_expired;

  // Decode who would win in IDLE, whether the LS request is malformed,
  // and the saturating/expiry values for the two counters.
  always_comb begin
    ls_is_store  = (ls_ctrl == CTRL_SB) || (ls_ctrl == CTRL_SH) || (ls_ctrl == CTRL_SW);
    ls_malformed = (ls_we != ls_is_store);
    starve_hit   = (starve_cnt_q == STARVE_LIMIT);
    grant_if     = if_req && (!ls_req || starve_hit);
    grant_ls     = ls_req && !grant_if;
    starve_inc   = (starve_cnt_q >= STARVE_LIMIT || starve_cnt_q == 4'hF)
                   ? starve_cnt_q : starve_cnt_q + 4'd1;
    wait_expired = ((wait_cnt_q + 8'd1) == WAIT_LIMIT);
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    ls_ack_d     = 1'b0;
    ls_err_d     = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_ctrl_d   = mem_ctrl_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          starve_cnt_d = 4'd0;
          wait_cnt_d   = 8'd0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_ctrl_d   = CTRL_LW;
          mem_addr_d   = if_addr;
          state_d      = FETCH;
        end else if (grant_ls) begin
          starve_cnt_d = if_req ? starve_inc : 4'd0;
          if (ls_malformed) begin
            ls_ack_d   = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = '0;
            state_d    = RESP;
          end else begin
            wait_cnt_d  = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we;
            mem_ctrl_d  = ls_ctrl;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            state_d     = DATA;
          end
        end
      end

      FETCH, DATA: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = mem_we_q ? '0 : mem_rdata;
          end
        end else if (wait_expired) begin
          mem_req_d  = 1'b0;
          wait_cnt_d = 8'd0;
          state_d    = RESP;
          if (state_q == FETCH) begin
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            ls_ack_d   = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Register state, counters and every output; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      starve_cnt_q <= 4'd0;
      if_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      ls_rdata_q   <= '0;
      ls_ack_q     <= 1'b0;
      ls_err_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_ctrl_q   <= 3'b000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      ls_rdata_q   <= ls_rdata_d;
      ls_ack_q     <= ls_ack_d;
      ls_err_q     <= ls_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_err    = ls_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// transactions, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MAX_WAIT     = 15;
  localparam int FETCH_STARVE = 4;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_err;
  logic              ls_req;
  logic              ls_we;
  logic [2:0]        ls_ctrl;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_ack;
  logic              ls_err;
  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_ctrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .FETCH_STARVE(FETCH_STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_ctrl(ls_ctrl), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending requests, starvation count, held rdata
  bit          if_pend;
  bit          ls_pend;
  int          starve_cnt;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_ls_rdata;
  logic [7:0]  glog;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Randomly raise new requests on idle requesters
  task automatic applyStimulus();
    if (!if_pend && $urandom_range(0, 99) < 55) begin
      if_pend = 1; if_req = 1'b1;
      if_addr = {16'h0000, 14'($urandom), 2'b00};
    end
    if (!ls_pend && $urandom_range(0, 99) < 70) begin
      ls_pend = 1; ls_req = 1'b1;
      ls_ctrl = 3'($urandom);
      ls_we   = (ls_ctrl inside {3'b101, 3'b110, 3'b111});
      if ($urandom_range(0, 9) == 0) ls_we = !ls_we;
      ls_addr  = {1'b1, 29'($urandom), 2'b00};
      ls_wdata = $urandom;
    end
  endtask

  // One arbitration round from an IDLE cycle; delay<0 means memory never answers
  task automatic runTransaction(input int delay, input logic [31:0] rdata_val);
    bit          win_if;
    bit          malformed;
    bit          is_store;
    bit          st;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
    logic        exp_we;
    logic [2:0]  exp_ctrl;
    int          hold_ok;
    if (!if_pend && !ls_pend) begin
      tick();
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_mem_req", 64'(mem_req), 64'd0);
      return;
    end
    win_if    = if_pend && (!ls_pend || starve_cnt == FETCH_STARVE);
    is_store  = (ls_ctrl inside {3'b101, 3'b110, 3'b111});
    malformed = !win_if && (ls_we != is_store);
    st        = !win_if && ls_we;
    if (win_if || !if_pend) starve_cnt = 0;
    else if (starve_cnt < FETCH_STARVE) starve_cnt++;
    exp_addr = win_if ? if_addr : ls_addr;
    exp_we   = win_if ? 1'b0 : ls_we;
    exp_ctrl = win_if ? 3'b010 : ls_ctrl;
    tick();
    glog = {glog[6:0], (mem_req === 1'b1 && mem_addr === if_addr && mem_we === 1'b0 && mem_ctrl === 3'b010)};
    if (malformed) begin
      checkOutput("bad_mem_req", 64'(mem_req), 64'd0);
      checkOutput("bad_ls_ack", 64'(ls_ack), 64'd1);
      checkOutput("bad_ls_err", 64'(ls_err), 64'd1);
      checkOutput("bad_ls_rdata", 64'(ls_rdata), 64'd0);
      checkOutput("bad_if_ack", 64'({if_ack, if_err}), 64'd0);
      checkOutput("bad_if_rdata_hold", 64'(if_rdata), 64'(exp_if_rdata));
      exp_ls_rdata = 32'h0;
      ls_req = 1'b0; ls_pend = 0;
    end else begin
      checkOutput("grant_mem_req", 64'(mem_req), 64'd1);
      checkOutput("grant_mem_addr", 64'(mem_addr), 64'(exp_addr));
      checkOutput("grant_mem_we", 64'(mem_we), 64'(exp_we));
      checkOutput("grant_mem_ctrl", 64'(mem_ctrl), 64'(exp_ctrl));
      if (st) checkOutput("grant_mem_wdata", 64'(mem_wdata), 64'(ls_wdata));
      checkOutput("grant_no_ack", 64'({if_ack, ls_ack}), 64'd0);
      checkOutput("grant_busy", 64'(busy), 64'd1);
      hold_ok = 0;
      if (delay < 0) begin
        repeat (MAX_WAIT - 1) begin
          mem_rdata = $urandom;
          tick();
          if (mem_req === 1'b1 && mem_addr === exp_addr && if_ack === 1'b0 && ls_ack === 1'b0) hold_ok++;
        end
        checkOutput("timeout_hold", 64'(hold_ok), 64'(MAX_WAIT - 1));
        exp_rd = 32'h0;
      end else begin
        repeat (delay) begin
          mem_rdata = $urandom;
          tick();
          if (mem_req === 1'b1 && mem_addr === exp_addr && if_ack === 1'b0 && ls_ack === 1'b0) hold_ok++;
        end
        checkOutput("wait_hold", 64'(hold_ok), 64'(delay));
        mem_ready = 1'b1;
        mem_rdata = rdata_val;
        exp_rd    = st ? 32'h0 : rdata_val;
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      checkOutput("done_mem_req", 64'(mem_req), 64'd0);
      if (win_if) begin
        checkOutput("if_ack", 64'(if_ack), 64'd1);
        checkOutput("if_err", 64'(if_err), 64'(delay < 0));
        checkOutput("if_rdata", 64'(if_rdata), 64'(exp_rd));
        checkOutput("ls_ack_quiet", 64'({ls_ack, ls_err}), 64'd0);
        checkOutput("ls_rdata_hold", 64'(ls_rdata), 64'(exp_ls_rdata));
        exp_if_rdata = exp_rd;
        if_req = 1'b0; if_pend = 0;
      end else begin
        checkOutput("ls_ack", 64'(ls_ack), 64'd1);
        checkOutput("ls_err", 64'(ls_err), 64'(delay < 0));
        checkOutput("ls_rdata", 64'(ls_rdata), 64'(exp_rd));
        checkOutput("if_ack_quiet", 64'({if_ack, if_err}), 64'd0);
        checkOutput("if_rdata_hold", 64'(if_rdata), 64'(exp_if_rdata));
        exp_ls_rdata = exp_rd;
        ls_req = 1'b0; ls_pend = 0;
      end
    end
    tick();
    checkOutput("resp_end_acks", 64'({if_ack, ls_ack, if_err, ls_err}), 64'd0);
    checkOutput("resp_end_busy", 64'(busy), 64'd0);
    checkOutput("resp_end_mem_req", 64'(mem_req), 64'd0);
  endtask

  // Hang guard
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    int d;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_ctrl = 3'b000; ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    if_pend = 0; ls_pend = 0; starve_cnt = 0; exp_if_rdata = '0; exp_ls_rdata = '0; glog = '0;
    repeat (2) tick();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_acks", 64'({if_ack, ls_ack, if_err, ls_err}), 64'd0);
    checkOutput("rst_mem_fields", 64'({mem_we, mem_ctrl, mem_addr}), 64'd0);
    checkOutput("rst_rdata", 64'({if_rdata, ls_rdata}), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] fetch only");
    if_pend = 1; if_req = 1'b1; if_addr = 32'h0000_0100;
    runTransaction(2, 32'h0000_0013);

    $display("[TB] simultaneous request");
    glog = '0;
    if_pend = 1; if_req = 1'b1; if_addr = 32'h0000_0300;
    ls_pend = 1; ls_req = 1'b1; ls_we = 1'b0; ls_ctrl = 3'b010; ls_addr = 32'h0000_0200;
    runTransaction(0, 32'h1234_5678);
    runTransaction(0, 32'h0BAD_F00D);
    checkOutput("simul_order", 64'(glog[1:0]), 64'(2'b01));

    $display("[TB] fetch starvation bound");
    glog = '0;
    if_pend = 1; if_req = 1'b1; if_addr = 32'h0000_0400;
    for (int i = 0; i < 6; i++) begin
      if (!ls_pend) begin
        ls_pend = 1; ls_req = 1'b1; ls_we = 1'b0; ls_ctrl = 3'b010;
        ls_addr = 32'h8000_1000 + 32'(i * 4);
      end
      runTransaction(0, $urandom);
    end
    checkOutput("starve_order", 64'(glog[5:0]), 64'(6'b000010));

    $display("[TB] malformed requests");
    ls_pend = 1; ls_req = 1'b1; ls_we = 1'b0; ls_ctrl = 3'b110; ls_addr = 32'h8000_0010;
    runTransaction(0, 32'hFFFF_FFFF);
    ls_pend = 1; ls_req = 1'b1; ls_we = 1'b1; ls_ctrl = 3'b010; ls_addr = 32'h8000_0014;
    runTransaction(0, 32'hFFFF_FFFF);

    $display("[TB] store timeout");
    ls_pend = 1; ls_req = 1'b1; ls_we = 1'b1; ls_ctrl = 3'b111;
    ls_addr = 32'h8000_2000; ls_wdata = 32'hDEAD_BEEF;
    runTransaction(-1, 32'h0);

    $display("[TB] reset during data phase");
    ls_pend = 1; ls_req = 1'b1; ls_we = 1'b0; ls_ctrl = 3'b010; ls_addr = 32'h8000_0040;
    tick();
    checkOutput("rst_mid_pre_req", 64'(mem_req), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_ack", 64'({if_ack, ls_ack}), 64'd0);
    rst = 1'b0; ls_req = 1'b0; ls_pend = 0; starve_cnt = 0;
    exp_if_rdata = '0; exp_ls_rdata = '0;
    tick();
    checkOutput("rst_after_quiet", 64'({busy, mem_req, ls_ack, if_ack}), 64'd0);
    if_pend = 1; if_req = 1'b1; if_addr = 32'h0000_0180;
    runTransaction(1, 32'h0000_0093);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      applyStimulus();
      d = int'($urandom_range(0, 19));
      if (d == 0) d = -1;
      else if (d == 1) d = MAX_WAIT - 1;
      else d = int'($urandom_range(0, 3));
      runTransaction(d, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
